imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- UART boot loader: the write side of instruction memory, which the core only ever reads.
- Takes a byte stream from the UART receiver, frames it, and writes 32-bit words into instruction memory starting at the reset PC.
- Holds the core off while loading, then replies with ACK/NAK through the UART transmitter.
- Sits between uart_mmio's RX/TX byte interfaces and the instruction memory write port.

Parameters:
BASE_ADDR, 32'h80000000, byte address of the first word written (the core's reset PC)
MAX_WORDS, 4096, largest accepted image length in words
TIMEOUT_CYCLES, 27000000, inter-byte timeout in clk cycles (used only with LOADER_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
tx_data  output  8  reply byte
tx_valid  output  1  reply byte valid; held until tx_ready
tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
imem_we  output  1  instruction memory write enable, one-cycle pulse
imem_addr  output  32  byte address of the write, word aligned
imem_wdata  output  32  write data
core_hold  output  1  high while a load is in progress; core PC and pipeline held in reset
load_done  output  1  one-cycle pulse on successful load
load_error  output  1  sticky error flag; cleared by rst or by the next accepted magic byte
word_count  output  16  words written in the current or last load

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0, including tx_data, imem_addr, imem_wdata and word_count.
- Frame format: 0xA5 magic, then 4-byte length N in words (little-endian), then 4*N payload bytes (each word little-endian), then 1 checksum byte (XOR of all payload bytes only).
- rx_valid has no backpressure. A byte is consumed in the cycle its strobe is seen.
- IDLE:
  - Non-0xA5 bytes are ignored.
  - On 0xA5: go to LEN; core_hold<=1; clear load_error, word_count, byte counter and checksum.
- LEN:
  - Collect 4 bytes.
  - After the 4th byte, if N==0 or N>MAX_WORDS: go to REPLY with NAK (0x15) and set load_error.
  - Otherwise go to DATA.
  - Bits of N above 16 must be zero, else NAK.
- DATA:
  - A 2-bit byte index assembles the word: byte0 -> [7:0] … byte3 -> [31:24].
  - Every byte is XORed into the checksum.
  - The cycle after the 4th byte of a word: imem_we=1 for exactly one cycle, imem_addr = BASE_ADDR + 4*word_count, imem_wdata = the assembled word. word_count increments in that same cycle.
  - When word_count reaches N, go to CSUM.
- CSUM:
  - Next byte == running checksum: go to REPLY with ACK (0x06).
  - Otherwise: REPLY with NAK and set load_error.
  - Words already written are not rolled back.
- REPLY:
  - tx_valid=1 and tx_data stable until the tx_valid && tx_ready handshake.
  - On handshake: go to IDLE, core_hold<=0. If the reply was ACK, pulse load_done for 1 cycle in that same cycle.
  - rx bytes arriving in REPLY are dropped.
- core_hold falls only on leaving REPLY, so the core restarts from BASE_ADDR with the new image.
- No imem write in the cycle core_hold falls: the last write always precedes the reply.
- Reset mid-frame: back to IDLE immediately; core_hold=0; imem_we=0; a partially assembled word is discarded; words already written stay in memory.
- word_count wraps never: it is bounded by MAX_WORDS <= 65535.

Optional Feature:
LOADER_TIMEOUT_EN:
- Defined: a counter restarts on every accepted rx byte in LEN, DATA and CSUM. If it reaches TIMEOUT_CYCLES with no byte, go to REPLY with NAK 0x15 and set load_error. The counter is idle in IDLE and REPLY.
- Undefined: no counter logic is synthesised; the loader waits indefinitely for the next byte.

Test Plan:
- Frame A5, 02 00 00 00, 13 00 00 00, 6F 00 00 00, csum 7C -> imem writes 0x00000013 @0x80000000 and 0x0000006F @0x80000004, one cycle each; tx_data=0x06; load_done pulse; core_hold low after the handshake; word_count=2.
- Same frame with csum 0x00 -> both words written; tx_data=0x15; load_error=1; no load_done.
- Length 0 (A5 00 00 00 00) -> no imem_we; immediate NAK; load_error=1. Next A5 clears load_error.
- Garbage bytes 00 FF 12 in IDLE -> no state change, core_hold stays 0; a following valid frame loads correctly.
- Hold tx_ready=0 for 50 cycles in REPLY while sending rx bytes -> tx_valid/tx_data stable; rx bytes ignored; finish when tx_ready=1.
- rst pulse after 6 payload bytes -> word 0 is written and word 1 is not; core_hold=0; all outputs 0. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stopping after 2 length bytes -> NAK at cycle 100.

Source files
------------

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader that frames a byte stream into 32-bit instruction memory writes and replies ACK/NAK.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module imem_uart_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          MAX_WORDS      = 4096,
  parameter int          TIMEOUT_CYCLES = 27000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, REPLY} state_t;
  localparam logic [7:0] MAGIC = 8'hA5;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  state_t state, state_n;
  logic [31:0] len, len_n, word_n;
  logic [23:0] word;
  logic [1:0]  bidx;
  logic [7:0]  csum;
  logic        last, len_bad, ack, tmo;
  assign last      = bidx == 2'd3;
  assign len_n     = {rx_data, len[31:8]};
  assign word_n    = {rx_data, word};
  assign len_bad   = |len_n[31:16] || len_n[15:0] == 16'd0 || {16'd0, len_n[15:0]} > MAX_WORDS;
  assign ack       = state == CSUM && rx_valid && rx_data == csum;
  assign tx_valid  = state == REPLY;
  assign core_hold = state != IDLE;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        busy;
  assign busy = state == LEN || state == DATA || state == CSUM;
  assign tmo  = busy && !rx_valid && tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_cnt <= '0;
    else tmo_cnt <= (!busy || rx_valid) ? '0 : tmo_cnt + 32'd1;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rx_valid && rx_data == MAGIC) state_n = LEN;
      LEN:     if (rx_valid && last) state_n = len_bad ? REPLY : DATA;
      DATA:    if (rx_valid && last && word_count + 16'd1 == len[15:0]) state_n = CSUM;
      CSUM:    if (rx_valid) state_n = REPLY;
      REPLY:   if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = REPLY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len        <= '0;
      word       <= '0;
      bidx       <= '0;
      csum       <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_data    <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= state == REPLY && tx_ready && tx_data == ACK;
      if (state == IDLE && state_n == LEN) begin
        load_error <= 1'b0;
        word_count <= '0;
        bidx       <= '0;
        csum       <= '0;
      end
      if (rx_valid && (state == LEN || state == DATA)) bidx <= bidx + 2'd1;
      if (rx_valid && state == LEN) len <= len_n;
      if (rx_valid && state == DATA) begin
        word <= word_n[31:8];
        csum <= csum ^ rx_data;
        if (last) begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
          imem_wdata <= word_n;
          word_count <= word_count + 16'd1;
        end
      end
      // reply byte is latched on entry so it stays stable through backpressure
      if (state != REPLY && state_n == REPLY) begin
        tx_data    <= ack ? ACK : NAK;
        load_error <= !ack;
      end
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: table-driven and randomized frames checked against a byte-level frame model.
module tb_imem_uart_loader;
  logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00, tx_data;
  logic        tx_valid, imem_we, core_hold, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;
  int vectors = 0, miscompares = 0, done_cnt = 0, exp_done = 0, bad_we = 0;
  logic [63:0] wq[$], ew[$];
  logic [31:0] pay[$];
  localparam logic [31:0] BASE = 32'h8000_0000;
  typedef struct {
    logic [31:0] n;
    int          np;
    logic [31:0] w0, w1;
    bit          send_cs;
    logic [7:0]  cs;
    logic [7:0]  tx;
    bit          err;
    int          wr;
    logic [15:0] wc;
  } vec_t;
  vec_t tv[8];
  always #5 clk = ~clk;
  imem_uart_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );
  always @(negedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (imem_we && !core_hold) bad_we++;
    if (load_done) done_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic gap(input int mx);
    repeat ($urandom_range(mx, 0)) @(negedge clk);
  endtask
  task automatic send_frame(input logic [31:0] n, input logic [7:0] cs, input bit with_cs, input int gmax);
    logic [31:0] w;
    send_byte(8'hA5);
    #1;
    chk("magic_clears_err", {31'd0, load_error}, 0);
    chk("magic_sets_hold", {31'd0, core_hold}, 1);
    gap(gmax);
    for (int i = 0; i < 4; i++) begin
      send_byte(n[8*i +: 8]);
      gap(gmax);
    end
    foreach (pay[k]) begin
      w = pay[k];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        gap(gmax);
      end
    end
    if (with_cs) send_byte(cs);
  endtask
  task automatic finish_reply(input logic [7:0] etx, input bit eerr, input logic [15:0] ewc, input string tag);
    for (int i = 0; i < 100 && tx_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 1);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, etx});
    chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, eerr});
    chk({tag, "_word_count"}, {16'd0, word_count}, {16'd0, ewc});
    chk({tag, "_hold_in_reply"}, {31'd0, core_hold}, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, etx == 8'h06});
    chk({tag, "_hold_released"}, {31'd0, core_hold}, 0);
    @(negedge clk);
    chk({tag, "_load_done_pulse"}, {31'd0, load_done}, 0);
    if (etx == 8'h06) exp_done++;
  endtask
  task automatic chk_writes(input string tag);
    #1;
    chk({tag, "_write_count"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq[i][63:32], ew[i][63:32]);
      chk($sformatf("%s_data%0d", tag, i), wq[i][31:0], ew[i][31:0]);
    end
    wq.delete();
    ew.delete();
  endtask
  initial begin
    logic [7:0]  cs, b;
    logic [31:0] w;
    int          nw;
    bit          good;
    tv[0] = '{32'd2, 2, 32'h13, 32'h6F, 1'b1, 8'h7C, 8'h06, 1'b0, 2, 16'd2};
    tv[1] = '{32'd2, 2, 32'h13, 32'h6F, 1'b1, 8'h00, 8'h15, 1'b1, 2, 16'd2};
    tv[2] = '{32'd0, 0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h15, 1'b1, 0, 16'd0};
    tv[3] = '{32'h0001_0001, 0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h15, 1'b1, 0, 16'd0};
    tv[4] = '{32'd4097, 0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h15, 1'b1, 0, 16'd0};
    tv[5] = '{32'd1, 1, 32'hDEADBEEF, 32'h0, 1'b1, 8'h22, 8'h06, 1'b0, 1, 16'd1};
    tv[6] = '{32'd1, 1, 32'h12345678, 32'h0, 1'b1, 8'h09, 8'h15, 1'b1, 1, 16'd1};
    tv[7] = '{32'd1, 1, 32'h12345678, 32'h0, 1'b1, 8'h08, 8'h06, 1'b0, 1, 16'd1};
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_imem_we", {31'd0, imem_we}, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_core_hold", {31'd0, core_hold}, 0);
    chk("rst_word_count", {16'd0, word_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    @(negedge clk);
    chk("garbage_hold", {31'd0, core_hold}, 0);
    chk("garbage_tx_valid", {31'd0, tx_valid}, 0);
    foreach (tv[i]) begin
      pay.delete();
      if (tv[i].np > 0) pay.push_back(tv[i].w0);
      if (tv[i].np > 1) pay.push_back(tv[i].w1);
      send_frame(tv[i].n, tv[i].cs, tv[i].send_cs, 0);
      finish_reply(tv[i].tx, tv[i].err, tv[i].wc, $sformatf("row%0d", i));
      if (tv[i].wr > 0) ew.push_back({BASE, tv[i].w0});
      if (tv[i].wr > 1) ew.push_back({BASE + 32'd4, tv[i].w1});
      chk_writes($sformatf("row%0d", i));
    end
    pay.delete();
    pay.push_back(32'hDEADBEEF);
    send_frame(32'd1, 8'h22, 1'b1, 0);
    for (int i = 0; i < 100 && tx_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      send_byte((i % 7 == 0) ? 8'hA5 : 8'($urandom));
      chk("bp_tx_valid", {31'd0, tx_valid}, 1);
      chk("bp_tx_data", {24'd0, tx_data}, 32'h06);
    end
    finish_reply(8'h06, 1'b0, 16'd1, "bp");
    ew.push_back({BASE, 32'hDEADBEEF});
    chk_writes("bp");
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("max_len_accepted", {31'd0, tx_valid}, 0);
    chk("max_len_hold", {31'd0, core_hold}, 1);
    foreach (tv[i]) if (i < 6) send_byte(8'((i < 4) ? 8'h44 - 8'(i * 16 + i) : 8'hAA + 8'(i)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_hold", {31'd0, core_hold}, 0);
    chk("midrst_imem_we", {31'd0, imem_we}, 0);
    chk("midrst_word_count", {16'd0, word_count}, 0);
    chk("midrst_imem_wdata", imem_wdata, 0);
    chk("midrst_tx_data", {24'd0, tx_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    ew.push_back({BASE, 32'h11223344});
    chk_writes("midrst");
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(1, 0) == 1) send_byte(8'h5A);
      nw = $urandom_range(6, 1);
      pay.delete();
      cs = 8'h00;
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        pay.push_back(w);
        ew.push_back({BASE + 32'(4 * k), w});
        for (int j = 0; j < 4; j++) cs = cs ^ w[8*j +: 8];
      end
      good = $urandom_range(3, 0) != 0;
      b = good ? cs : cs ^ 8'($urandom_range(255, 1));
      send_frame(32'(nw), b, 1'b1, 2);
      finish_reply(good ? 8'h06 : 8'h15, !good, 16'(nw), $sformatf("rnd%0d", r));
      chk_writes($sformatf("rnd%0d", r));
    end
    #1;
    chk("load_done_total", done_cnt, exp_done);
    chk("write_outside_hold", bad_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
